// File: rtl/psum_writeback_ctrl.sv
// Partial-sum writeback sequencer: drains OFIFO vectors into the psum SRAM,
// either overwriting or doing a read / accumulate / write per vector.
module psum_writeback_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  num_vec,
    input  logic [10:0] base_addr,
    input  logic        acc_mode,
    input  logic        ofifo_valid,
    output logic        ofifo_rd,
    output logic [10:0] pmem_addr,
    output logic        pmem_rd,
    output logic        pmem_wr,
    output logic        sfp_acc_en,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_RD   = 3'd2,
        S_ACC  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  num_vec_q, num_vec_d;
    logic [10:0] base_q, base_d;
    logic        acc_q, acc_d;
    logic [4:0]  idx_q, idx_d;
    logic [10:0] vec_addr;

    // 11-bit sum wraps naturally at 2048.
    assign vec_addr = base_q + {6'd0, idx_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            num_vec_q <= 5'd0;
            base_q    <= 11'd0;
            acc_q     <= 1'b0;
            idx_q     <= 5'd0;
        end else begin
            state_q   <= state_d;
            num_vec_q <= num_vec_d;
            base_q    <= base_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        num_vec_d  = num_vec_q;
        base_d     = base_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        ofifo_rd   = 1'b0;
        pmem_addr  = 11'd0;
        pmem_rd    = 1'b0;
        pmem_wr    = 1'b0;
        sfp_acc_en = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                // Job parameters are only captured here, so starts elsewhere are ignored.
                if (start) begin
                    num_vec_d = num_vec;
                    base_d    = base_addr;
                    acc_d     = acc_mode;
                    idx_d     = 5'd0;
                    state_d   = (num_vec == 5'd0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (ofifo_valid) begin
                    state_d = acc_q ? S_RD : S_WR;
                end
            end
            S_RD: begin
                pmem_rd   = 1'b1;
                pmem_addr = vec_addr;
                state_d   = S_ACC;
            end
            S_ACC: begin
                sfp_acc_en = 1'b1;
                pmem_addr  = vec_addr;
                state_d    = S_WR;
            end
            S_WR: begin
                pmem_wr   = 1'b1;
                ofifo_rd  = 1'b1;
                pmem_addr = vec_addr;
                idx_d     = idx_q + 5'd1;
                state_d   = (idx_q == num_vec_q - 5'd1) ? S_DONE : S_WAIT;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_psum_writeback_ctrl.sv
// Random and directed drain jobs checked cycle by cycle against a
// transaction-level model that expands each accepted vector into its strobe trace.
module tb_psum_writeback_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  num_vec;
    logic [10:0] base_addr;
    logic        acc_mode;
    logic        ofifo_valid;
    logic        ofifo_rd;
    logic [10:0] pmem_addr;
    logic        pmem_rd;
    logic        pmem_wr;
    logic        sfp_acc_en;
    logic        busy;
    logic        done;

    psum_writeback_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_vec    (num_vec),
        .base_addr  (base_addr),
        .acc_mode   (acc_mode),
        .ofifo_valid(ofifo_valid),
        .ofifo_rd   (ofifo_rd),
        .pmem_addr  (pmem_addr),
        .pmem_rd    (pmem_rd),
        .pmem_wr    (pmem_wr),
        .sfp_acc_en (sfp_acc_en),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Output word layout: {busy, done, pmem_rd, pmem_wr, ofifo_rd, sfp_acc_en, pmem_addr}
    function automatic logic [16:0] mk(input logic b, input logic d, input logic r,
                                       input logic w, input logic o, input logic a,
                                       input logic [10:0] ad);
        return {b, d, r, w, o, a, ad};
    endfunction

    function automatic logic [16:0] dut_word();
        return {busy, done, pmem_rd, pmem_wr, ofifo_rd, sfp_acc_en, pmem_addr};
    endfunction

    // Reference model: queue of deterministic upcoming cycles plus vectors still owed.
    logic [16:0] exp_q[$];
    int          vec_left = 0;
    int          vec_idx  = 0;
    int          m_nv     = 0;
    logic [10:0] m_base   = 11'd0;
    logic        m_acc    = 1'b0;
    int          rd_cnt   = 0;

    function automatic bit model_idle();
        return (exp_q.size() == 0) && (vec_left == 0);
    endfunction

    task automatic model_clear();
        exp_q.delete();
        vec_left = 0;
        vec_idx  = 0;
        rd_cnt   = 0;
    endtask

    // One clock: check outputs of the current cycle, drive inputs, advance the model.
    task automatic cycle(input logic st, input logic [4:0] nv, input logic [10:0] ba,
                         input logic am, input logic vld);
        logic [16:0] cur;
        logic [10:0] a;
        bit idle, waiting;
        @(negedge clk);
        idle    = model_idle();
        waiting = (exp_q.size() == 0) && (vec_left > 0);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else if (waiting)     cur = mk(1, 0, 0, 0, 0, 0, 11'd0);
        else                  cur = 17'd0;
        check_eq("outputs", {15'd0, dut_word()}, {15'd0, cur});
        if (ofifo_rd) rd_cnt++;
        if (cur[15]) check_eq("ofifo_rd_per_job", rd_cnt, m_nv);

        start       = st;
        num_vec     = nv;
        base_addr   = ba;
        acc_mode    = am;
        ofifo_valid = vld;

        if (idle && st) begin
            m_nv   = int'(nv);
            m_base = ba;
            m_acc  = am;
            rd_cnt = 0;
            if (nv == 5'd0) exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 11'd0));
            else begin
                vec_left = int'(nv);
                vec_idx  = 0;
            end
        end else if (waiting && vld) begin
            a = m_base + 11'(vec_idx);
            if (m_acc) begin
                exp_q.push_back(mk(1, 0, 1, 0, 0, 0, a));
                exp_q.push_back(mk(1, 0, 0, 0, 0, 1, a));
            end
            exp_q.push_back(mk(1, 0, 0, 1, 1, 0, a));
            vec_idx++;
            vec_left--;
            if (vec_left == 0) exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 11'd0));
        end
    endtask

    task automatic run_job(input logic [4:0] nv, input logic [10:0] ba, input logic am);
        int guard;
        cycle(1'b1, nv, ba, am, 1'b1);
        guard = 0;
        while (!model_idle() && guard < 200) begin
            cycle(1'b0, 5'd0, 11'd0, 1'b0, 1'b1);
            guard++;
        end
        check_eq("job_terminates", guard < 200, 1);
        cycle(1'b0, 5'd0, 11'd0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        ofifo_valid = 1'b0;
        #1;
        check_eq("reset_outputs", {15'd0, dut_word()}, 32'd0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_hold", {15'd0, dut_word()}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic st;
        start = 0; num_vec = 0; base_addr = 0; acc_mode = 0; ofifo_valid = 0;
        apply_reset();

        // Accumulate, two vectors at 0x010.
        run_job(5'd2, 11'h010, 1'b1);
        // Overwrite, three vectors wrapping past 0x7FF.
        run_job(5'd3, 11'h7FF, 1'b0);
        // Empty job.
        run_job(5'd0, 11'h123, 1'b1);

        // OFIFO empty for five WAIT cycles.
        cycle(1'b1, 5'd1, 11'h055, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 5'd0, 11'd0, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, 5'd0, 11'd0, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 11'd0, 1'b0, 1'b0);

        // Abort during ACC of vector 1 of 4, then run a full job.
        cycle(1'b1, 5'd4, 11'h200, 1'b1, 1'b1);
        repeat (7) cycle(1'b0, 5'd0, 11'd0, 1'b0, 1'b1);
        check_eq("in_acc_before_reset", sfp_acc_en, 1'b1);
        apply_reset();
        cycle(1'b0, 5'd0, 11'd0, 1'b0, 1'b1);
        run_job(5'd4, 11'h3F0, 1'b1);

        // start held on every busy cycle with different parameters must be ignored.
        cycle(1'b1, 5'd2, 11'h040, 1'b1, 1'b1);
        for (int i = 0; i < 40 && !model_idle(); i++)
            cycle(1'b1, 5'd9, 11'h555, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 11'd0, 1'b0, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            st = model_idle() ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 5) == 0);
            cycle(st, 5'($urandom_range(0, 16)), 11'($urandom_range(0, 2047)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 200 && !model_idle(); i++)
            cycle(1'b0, 5'd0, 11'd0, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 11'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
